// File: rtl/mem_access_stage.sv
// MEM pipeline stage: multi-cycle word-addressed data memory with an IDLE/BUSY
// sequencer that stalls upstream, followed by the MEM/WB pipeline register.
module mem_access_stage #(
  parameter int DEPTH  = 256,
  parameter int ADDR_W = 8,
  parameter int LAT    = 2
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        MemRead_i,
  input  logic        MemWrite_i,
  input  logic [31:0] Addr_i,
  input  logic [31:0] WriteData_i,
  input  logic [1:0]  WB_i,
  input  logic [4:0]  RdAddr_i,
  output logic        stall_o,
  output logic [1:0]  WB_o,
  output logic [31:0] ReadData_o,
  output logic [31:0] ALU_o,
  output logic [4:0]  RdAddr_o,
  output logic        misalign_o
);

  typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_t;

  localparam logic [3:0] LAT_M1 = 4'(LAT - 1);

  state_t              state_r, state_nxt_s;
  logic [3:0]          cnt_r, cnt_nxt_s;
  logic [31:0]         mem_r [DEPTH];
  logic                acc_s, req_s, mis_s, stall_s, done_s, wr_en_s, rd_sel_s;
  logic [ADDR_W-1:0]   idx_s;
  logic [31:0]         rd_data_s;

  assign acc_s     = MemRead_i | MemWrite_i;
  assign req_s     = acc_s & (Addr_i[1:0] == 2'b00);
  assign mis_s     = acc_s & (Addr_i[1:0] != 2'b00);
  assign idx_s     = Addr_i[ADDR_W+1:2];
  assign done_s    = (state_r == BUSY) & (cnt_r == 4'd0);
  assign wr_en_s   = done_s & MemWrite_i & ~mis_s;
  assign rd_sel_s  = MemRead_i & ~MemWrite_i & ~mis_s;
  assign rd_data_s = rd_sel_s ? mem_r[idx_s] : 32'd0;
  // Stall is forced low while reset is held so upstream never sees a stale request.
  assign stall_o   = stall_s & rst_i;

  // Sequencer state and latency counter
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_r <= IDLE;
      cnt_r   <= 4'd0;
    end else begin
      state_r <= state_nxt_s;
      cnt_r   <= cnt_nxt_s;
    end
  end

  // Next-state logic
  always_comb begin
    state_nxt_s = state_r;
    cnt_nxt_s   = cnt_r;
    case (state_r)
      IDLE: begin
        if (req_s) begin
          state_nxt_s = BUSY;
          cnt_nxt_s   = LAT_M1;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      BUSY: begin
        if (cnt_r != 4'd0) begin
          cnt_nxt_s = cnt_r - 4'd1;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      default: begin
        state_nxt_s = IDLE;
        cnt_nxt_s   = 4'd0;
      end
    endcase
  end

  // Stall decode: high for every cycle of an aligned access except the completion cycle
  always_comb begin
    stall_s = 1'b0;
    case (state_r)
      IDLE:    stall_s = req_s;
      BUSY:    stall_s = (cnt_r != 4'd0);
      default: stall_s = 1'b0;
    endcase
  end

  // Data memory array; contents survive reset, store commits only at completion
  always_ff @(posedge clk_i) begin
    if (wr_en_s) begin
      mem_r[idx_s] <= WriteData_i;
    end
  end

  // MEM/WB register: loads on non-stall edges, inserts a bubble while stalled
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      WB_o       <= 2'b00;
      ReadData_o <= 32'd0;
      ALU_o      <= 32'd0;
      RdAddr_o   <= 5'd0;
      misalign_o <= 1'b0;
    end else begin
      misalign_o <= mis_s & (state_r == IDLE);
      if (!stall_s) begin
        WB_o       <= mis_s ? 2'b00 : WB_i;
        ReadData_o <= rd_data_s;
        ALU_o      <= Addr_i;
        RdAddr_o   <= RdAddr_i;
      end else begin
        WB_o       <= 2'b00;
      end
    end
  end

endmodule

// File: tb/tb_mem_access_stage.sv
// Directed bench for mem_access_stage: a LAT=2 instance for the main sequence and
// a LAT=1 instance, held in reset until its own short phase at the end.
module tb_mem_access_stage;

  logic        clk = 1'b0;
  logic        rst_a, rst_b;
  logic        mem_read, mem_write;
  logic [31:0] addr, wdata;
  logic [1:0]  wb_in;
  logic [4:0]  rd_in;

  logic        stall_a, mis_a, stall_b, mis_b;
  logic [1:0]  wb_a, wb_b;
  logic [31:0] rdata_a, alu_a, rdata_b, alu_b;
  logic [4:0]  rd_a, rd_b;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  mem_access_stage #(.DEPTH(256), .ADDR_W(8), .LAT(2)) u_dut_lat2 (
    .clk_i(clk), .rst_i(rst_a), .MemRead_i(mem_read), .MemWrite_i(mem_write),
    .Addr_i(addr), .WriteData_i(wdata), .WB_i(wb_in), .RdAddr_i(rd_in),
    .stall_o(stall_a), .WB_o(wb_a), .ReadData_o(rdata_a), .ALU_o(alu_a),
    .RdAddr_o(rd_a), .misalign_o(mis_a)
  );

  mem_access_stage #(.DEPTH(256), .ADDR_W(8), .LAT(1)) u_dut_lat1 (
    .clk_i(clk), .rst_i(rst_b), .MemRead_i(mem_read), .MemWrite_i(mem_write),
    .Addr_i(addr), .WriteData_i(wdata), .WB_i(wb_in), .RdAddr_i(rd_in),
    .stall_o(stall_b), .WB_o(wb_b), .ReadData_o(rdata_b), .ALU_o(alu_b),
    .RdAddr_o(rd_b), .misalign_o(mis_b)
  );

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic set_op(input logic rd, input logic wr, input logic [31:0] a,
                        input logic [31:0] d, input logic [1:0] wb, input logic [4:0] rda);
    @(negedge clk);
    mem_read  = rd;
    mem_write = wr;
    addr      = a;
    wdata     = d;
    wb_in     = wb;
    rd_in     = rda;
  endtask

  // Check the combinational stall before the edge, then advance past the edge.
  task automatic step(input bit sel_b, input logic exp_stall, input string tag);
    #1;
    check_eq({tag, "_stall"}, {31'd0, sel_b ? stall_b : stall_a}, {31'd0, exp_stall});
    @(posedge clk);
    #1;
  endtask

  task automatic check_wb(input bit sel_b, input string tag, input logic [1:0] wb,
                          input logic [31:0] rdata, input logic [31:0] alu, input logic [4:0] rda);
    check_eq({tag, "_wb"},    {30'd0, sel_b ? wb_b : wb_a}, {30'd0, wb});
    check_eq({tag, "_rdata"}, sel_b ? rdata_b : rdata_a, rdata);
    check_eq({tag, "_alu"},   sel_b ? alu_b : alu_a, alu);
    check_eq({tag, "_rd"},    {27'd0, sel_b ? rd_b : rd_a}, {27'd0, rda});
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_a = 1'b0; rst_b = 1'b0;
    mem_read = 1'b0; mem_write = 1'b0; addr = 32'd0; wdata = 32'd0;
    wb_in = 2'b00; rd_in = 5'd0;
    #12;
    check_wb(1'b0, "reset", 2'b00, 32'd0, 32'd0, 5'd0);
    check_eq("reset_stall", {31'd0, stall_a}, 32'd0);
    check_eq("reset_mis",   {31'd0, mis_a},   32'd0);
    @(negedge clk);
    rst_a = 1'b1;

    // Store then load
    set_op(1'b0, 1'b1, 32'h10, 32'hDEADBEEF, 2'b00, 5'd0);
    step(1'b0, 1'b1, "sw1_c0"); check_eq("sw1_bubble0", {30'd0, wb_a}, 32'd0);
    step(1'b0, 1'b1, "sw1_c1"); check_eq("sw1_bubble1", {30'd0, wb_a}, 32'd0);
    step(1'b0, 1'b0, "sw1_c2");
    set_op(1'b1, 1'b0, 32'h10, 32'd0, 2'b11, 5'd5);
    step(1'b0, 1'b1, "lw1_c0");
    step(1'b0, 1'b1, "lw1_c1");
    step(1'b0, 1'b0, "lw1_c2");
    check_wb(1'b0, "lw1", 2'b11, 32'hDEADBEEF, 32'h10, 5'd5);

    // ALU op passes through in one cycle
    set_op(1'b0, 1'b0, 32'h1234, 32'd0, 2'b10, 5'd7);
    step(1'b0, 1'b0, "alu");
    check_wb(1'b0, "alu", 2'b10, 32'd0, 32'h1234, 5'd7);

    // Misaligned store to the same word as 0x10 must not write
    set_op(1'b0, 1'b1, 32'h13, 32'h55, 2'b10, 5'd8);
    step(1'b0, 1'b0, "mis");
    check_eq("mis_pulse", {31'd0, mis_a}, 32'd1);
    check_eq("mis_wb",    {30'd0, wb_a},  32'd0);
    set_op(1'b0, 1'b0, 32'h0, 32'd0, 2'b00, 5'd0);
    step(1'b0, 1'b0, "mis_next");
    check_eq("mis_pulse_end", {31'd0, mis_a}, 32'd0);
    set_op(1'b1, 1'b0, 32'h10, 32'd0, 2'b11, 5'd6);
    step(1'b0, 1'b1, "lw2_c0");
    step(1'b0, 1'b1, "lw2_c1");
    step(1'b0, 1'b0, "lw2_c2");
    check_wb(1'b0, "lw2", 2'b11, 32'hDEADBEEF, 32'h10, 5'd6);

    // Reset in the middle of a store
    set_op(1'b0, 1'b1, 32'h20, 32'h1, 2'b00, 5'd9);
    step(1'b0, 1'b1, "sw01_c0");
    step(1'b0, 1'b1, "sw01_c1");
    step(1'b0, 1'b0, "sw01_c2");
    set_op(1'b0, 1'b1, 32'h20, 32'hCAFEF00D, 2'b00, 5'd9);
    step(1'b0, 1'b1, "swcf_c0");
    rst_a = 1'b0;
    #1;
    check_wb(1'b0, "rst_mid", 2'b00, 32'd0, 32'd0, 5'd0);
    check_eq("rst_mid_stall", {31'd0, stall_a}, 32'd0);
    set_op(1'b0, 1'b0, 32'h0, 32'd0, 2'b00, 5'd0);
    @(negedge clk);
    rst_a = 1'b1;
    set_op(1'b1, 1'b0, 32'h20, 32'd0, 2'b11, 5'd3);
    step(1'b0, 1'b1, "lw20_c0");
    step(1'b0, 1'b1, "lw20_c1");
    step(1'b0, 1'b0, "lw20_c2");
    check_wb(1'b0, "lw20", 2'b11, 32'h1, 32'h20, 5'd3);

    // Address wrap modulo DEPTH words
    set_op(1'b0, 1'b1, 32'h400, 32'hA5A5A5A5, 2'b00, 5'd0);
    step(1'b0, 1'b1, "swwrap_c0");
    step(1'b0, 1'b1, "swwrap_c1");
    step(1'b0, 1'b0, "swwrap_c2");
    set_op(1'b1, 1'b0, 32'h0, 32'd0, 2'b11, 5'd4);
    step(1'b0, 1'b1, "lwwrap_c0");
    step(1'b0, 1'b1, "lwwrap_c1");
    step(1'b0, 1'b0, "lwwrap_c2");
    check_wb(1'b0, "lwwrap", 2'b11, 32'hA5A5A5A5, 32'h0, 5'd4);

    // Back-to-back loads: bubble, bubble, load1, bubble, bubble, load2
    set_op(1'b1, 1'b0, 32'h10, 32'd0, 2'b11, 5'd1);
    step(1'b0, 1'b1, "bb1_c0"); check_eq("bb1_bub0", {30'd0, wb_a}, 32'd0);
    step(1'b0, 1'b1, "bb1_c1"); check_eq("bb1_bub1", {30'd0, wb_a}, 32'd0);
    step(1'b0, 1'b0, "bb1_c2");
    check_wb(1'b0, "bb1", 2'b11, 32'hDEADBEEF, 32'h10, 5'd1);
    set_op(1'b1, 1'b0, 32'h0, 32'd0, 2'b11, 5'd2);
    step(1'b0, 1'b1, "bb2_c0");
    check_wb(1'b0, "bb2_bub0", 2'b00, 32'hDEADBEEF, 32'h10, 5'd1);
    step(1'b0, 1'b1, "bb2_c1"); check_eq("bb2_bub1", {30'd0, wb_a}, 32'd0);
    step(1'b0, 1'b0, "bb2_c2");
    check_wb(1'b0, "bb2", 2'b11, 32'hA5A5A5A5, 32'h0, 5'd2);

    // LAT=1 instance: stall pattern 1,0,1,0 for the same store/load pair
    set_op(1'b0, 1'b0, 32'h0, 32'd0, 2'b00, 5'd0);
    check_wb(1'b1, "l1_reset", 2'b00, 32'd0, 32'd0, 5'd0);
    @(negedge clk);
    rst_b = 1'b1;
    set_op(1'b0, 1'b1, 32'h10, 32'hDEADBEEF, 2'b00, 5'd0);
    step(1'b1, 1'b1, "l1_sw_c0"); check_eq("l1_sw_bub", {30'd0, wb_b}, 32'd0);
    step(1'b1, 1'b0, "l1_sw_c1");
    set_op(1'b1, 1'b0, 32'h10, 32'd0, 2'b11, 5'd5);
    step(1'b1, 1'b1, "l1_lw_c0");
    step(1'b1, 1'b0, "l1_lw_c1");
    check_wb(1'b1, "l1_lw", 2'b11, 32'hDEADBEEF, 32'h10, 5'd5);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
